// File: rtl/button_pkg.sv
// button_pkg: shared state encoding and default timing for the button press classifier.
package button_pkg;

    typedef enum logic [1:0] {IDLE, PRESSED, HELD} t_btn_state;

    localparam int c_CLK_HZ            = 25000000;
    localparam int c_LONG_PRESS_25M    = c_CLK_HZ;
    localparam int c_REPEAT_PERIOD_25M = c_CLK_HZ / 5;

endpackage

// File: rtl/button_press_classifier_if.sv
// button_press_classifier_if: debounced switch level in, one-cycle event pulses and held level out.
interface button_press_classifier_if;

    logic i_Switch;
    logic o_Press;
    logic o_Release;
    logic o_Short;
    logic o_Long;
    logic o_Repeat;
    logic o_Held;

    modport master (output i_Switch, input o_Press, o_Release, o_Short, o_Long, o_Repeat, o_Held);
    modport slave  (input i_Switch, output o_Press, o_Release, o_Short, o_Long, o_Repeat, o_Held);

endinterface

// File: rtl/button_press_classifier.sv
// button_press_classifier: turns a debounced button level into press/release/short/long/repeat pulses.
module button_press_classifier
    import button_pkg::*;
#(
    parameter int c_LONG_PRESS    = c_LONG_PRESS_25M,
    parameter int c_REPEAT_PERIOD = c_REPEAT_PERIOD_25M,
    parameter int c_REPEAT_EN     = 1,
    parameter int c_COUNT_WIDTH   = 25
) (
    input logic i_Clk,
    input logic i_Rst_L,
    button_press_classifier_if.slave bus
);

    localparam logic [c_COUNT_WIDTH-1:0] c_LONG_CNT   = c_COUNT_WIDTH'(c_LONG_PRESS);
    localparam logic [c_COUNT_WIDTH-1:0] c_REPEAT_CNT = c_COUNT_WIDTH'(c_REPEAT_PERIOD);
    localparam logic [c_COUNT_WIDTH-1:0] c_ONE        = c_COUNT_WIDTH'(1);

    t_btn_state r_State, w_State;
    logic [c_COUNT_WIDTH-1:0] r_Count, w_Count;
    logic r_Prev;
    logic w_Press, w_Release, w_Short, w_Long, w_Repeat;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_State <= IDLE;
            r_Count <= '0;
        end else begin
            r_State <= w_State;
            r_Count <= w_Count;
        end
    end

    // A zero sample is always a release, checked before any threshold.
    always_comb begin
        w_State   = r_State;
        w_Count   = r_Count;
        w_Press   = 1'b0;
        w_Release = 1'b0;
        w_Short   = 1'b0;
        w_Long    = 1'b0;
        w_Repeat  = 1'b0;
        case (r_State)
            IDLE: if (bus.i_Switch && !r_Prev) begin
                w_Press = 1'b1;
                w_Count = c_ONE;
                w_State = PRESSED;
            end
            PRESSED: if (!bus.i_Switch) begin
                w_Release = 1'b1;
                w_Short   = 1'b1;
                w_Count   = '0;
                w_State   = IDLE;
            end else if (r_Count == c_LONG_CNT) begin
                w_Long  = 1'b1;
                w_Count = c_ONE;
                w_State = HELD;
            end else begin
                w_Count = r_Count + c_ONE;
            end
            HELD: if (!bus.i_Switch) begin
                w_Release = 1'b1;
                w_Count   = '0;
                w_State   = IDLE;
            end else if (r_Count == c_REPEAT_CNT) begin
                w_Repeat = c_REPEAT_EN != 0;
                w_Count  = c_ONE;
            end else begin
                w_Count = r_Count + c_ONE;
            end
            default: w_State = IDLE;
        endcase
    end

    // r_Prev resets high so a button held through reset needs a fresh press.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_Prev        <= 1'b1;
            bus.o_Press   <= 1'b0;
            bus.o_Release <= 1'b0;
            bus.o_Short   <= 1'b0;
            bus.o_Long    <= 1'b0;
            bus.o_Repeat  <= 1'b0;
            bus.o_Held    <= 1'b0;
        end else begin
            r_Prev        <= bus.i_Switch;
            bus.o_Press   <= w_Press;
            bus.o_Release <= w_Release;
            bus.o_Short   <= w_Short;
            bus.o_Long    <= w_Long;
            bus.o_Repeat  <= w_Repeat;
            bus.o_Held    <= (w_State != IDLE) || w_Release;
        end
    end

endmodule

// File: doc/button_press_classifier.md
Name: button_press_classifier

Overview:
Consumes the debounced, clock-synchronous level from the switch debouncer and turns each press into one-cycle event pulses. It distinguishes a short press from a long press and generates auto-repeat ticks while the button stays held. Its outputs drive the menu and control FSMs, so those FSMs never handle raw levels or timing.

Parameters:
c_LONG_PRESS, 25000000, cycles a press must exceed to count as long (1 s at 25 MHz); must be ≥1.
c_REPEAT_PERIOD, 5000000, cycles between auto-repeat pulses once long-held (200 ms at 25 MHz); must be ≥1.
c_REPEAT_EN, 1, 1 enables o_Repeat; 0 ties o_Repeat to 0.
c_COUNT_WIDTH, 25, counter width; c_LONG_PRESS and c_REPEAT_PERIOD must each be < 2^c_COUNT_WIDTH.

Ports:
i_Clk  in  1  system clock, all logic on the rising edge
i_Rst_L  in  1  synchronous active-low reset
i_Switch  in  1  debounced button level, 1 = pressed, already synchronous to i_Clk
o_Press  out  1  one-cycle pulse on press
o_Release  out  1  one-cycle pulse on every release
o_Short  out  1  one-cycle pulse on release of a short press
o_Long  out  1  one-cycle pulse when a press becomes long
o_Repeat  out  1  one-cycle auto-repeat pulse while long-held
o_Held  out  1  level, 1 while the FSM is in PRESSED or HELD

Behaviour:
- Interface: one clock, i_Clk. Reset i_Rst_L is synchronous and active-low.
- Reset (i_Rst_L=0 at an edge): state=IDLE, counter=0, r_Prev=1, all outputs 0.
- r_Prev reset to 1: a button held through reset produces no press until it is released and pressed again.
- Reset mid-press: outputs go to 0 on the next cycle. No o_Release or o_Short is emitted.
- All outputs are registered. Timing notation: "at edge E" means the output is high for exactly the cycle after E.
- T0 = first edge that samples i_Switch=1 with r_Prev=0. D = number of consecutive edges sampling 1, starting at T0.
- States: IDLE, PRESSED, HELD.
- IDLE:
  - Rising edge at T0: o_Press=1, counter<=1, go to PRESSED.
  - Any other sample: no event.
- PRESSED, edge sampling 0: o_Release=1, o_Short=1, counter<=0, go to IDLE.
- PRESSED, edge sampling 1:
  - If counter==c_LONG_PRESS: o_Long=1, counter<=1, go to HELD.
  - Otherwise: counter<=counter+1.
  - Net result: D ≤ c_LONG_PRESS gives a short press; D > c_LONG_PRESS fires o_Long at edge T0+c_LONG_PRESS.
- HELD, edge sampling 0: o_Release=1 (no o_Short), counter<=0, go to IDLE.
- HELD, edge sampling 1:
  - If counter==c_REPEAT_PERIOD: o_Repeat=c_REPEAT_EN, counter<=1.
  - Otherwise: counter<=counter+1.
  - Repeats therefore fire at T0+c_LONG_PRESS+k·c_REPEAT_PERIOD, k≥1.
- Release takes priority: a 0 sample is always handled as release, never as a threshold hit.
- The counter is compared only for equality. It never exceeds the active threshold, so there is no wrap-around.
- Boundary cases:
  - c_REPEAT_PERIOD=1: o_Repeat is high every cycle in HELD after the o_Long cycle.
  - c_LONG_PRESS=1: a 1-sample press is short; a 2-sample press is long.
- At most one of o_Press / o_Long / o_Repeat / o_Release is high per cycle. o_Short only ever accompanies o_Release.
- o_Held=1 in the cycle after T0 through the cycle of o_Release, inclusive.

Decomposition:
- Shared package button_pkg:
  - state enum t_btn_state {IDLE, PRESSED, HELD}
  - default timing constants c_LONG_PRESS_25M and c_REPEAT_PERIOD_25M
  - clock-rate constant c_CLK_HZ=25000000
- No sub-module needed. The edge register, FSM and counter stay in one module.
- Optional: instantiate Debounce_Switch ahead of it in a wrapper, not inside this block.

Test Plan:
All scenarios use c_LONG_PRESS=10 and c_REPEAT_PERIOD=4.
1. D=5 (high T0..T0+4, low at T0+5) -> o_Press at T0; o_Release+o_Short at T0+5; no o_Long; o_Held high for 6 cycles.
2. D=10 -> short press: o_Short at T0+10, o_Long never asserts. D=11 -> o_Long at T0+10, o_Release at T0+11, no o_Short.
3. D=25 -> o_Long at T0+10; o_Repeat at T0+14, T0+18, T0+22; o_Release at T0+25; no o_Short. Repeat with c_REPEAT_EN=0 -> o_Repeat never high.
4. i_Switch=1 before and during reset, then released after reset -> no o_Press and no o_Release. The next press gives o_Press normally.
5. Reset asserted at T0+12 (HELD) -> all outputs 0 on the next cycle; no o_Release. Switch held after reset and then released -> no events.
6. Back-to-back presses 1 low cycle apart (D=3, gap 1, D=3) -> two o_Press / o_Short pairs; one-hot output check passes every cycle.
